// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between two requesters. Each granted
// operation is held on the ALU for its execution window, and the result is kept in a response register.
module alu_arbiter #(
  parameter int DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [14:0] req0_ctrl,
  input  logic [31:0] req0_src1,
  input  logic [31:0] req0_src2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [14:0] req1_ctrl,
  input  logic [31:0] req1_src1,
  input  logic [31:0] req1_src2,
  output logic [14:0] alu_control,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  input  logic [31:0] alu_result,
  input  logic [31:0] div_odd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [31:0] rsp_rem,
  output logic        rsp_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  logic           r_last_grant;
  logic [CW-1:0]  r_cnt;
  logic [14:0]    r_alu_ctrl;
  logic [31:0]    r_alu_src1;
  logic [31:0]    r_alu_src2;
  logic           r_rsp_valid;
  logic           r_rsp_id;
  logic [31:0]    r_rsp_result;
  logic [31:0]    r_rsp_rem;
  logic           r_rsp_err;

  logic           w_win;
  logic           w_accept;
  logic [14:0]    w_ctrl;
  logic [31:0]    w_src1;
  logic [31:0]    w_src2;
  logic [13:0]    w_low;
  logic           w_legal;

  // Handshake: a request transfers on the rising edge where reqN_valid and
  // reqN_ready are both high; the response transfers where rsp_valid and rsp_ready are both high.
  always_comb begin
    w_win    = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    w_accept = (r_state == S_IDLE) && (req0_valid || req1_valid) && !rst;
    w_ctrl   = w_win ? req1_ctrl : req0_ctrl;
    w_src1   = w_win ? req1_src1 : req0_src1;
    w_src2   = w_win ? req1_src2 : req0_src2;
    w_low    = w_ctrl[13:0];
    w_legal  = !w_ctrl[14] && (w_low != 14'd0) && ((w_low & (w_low - 14'd1)) == 14'd0);
  end

  assign req0_ready  = w_accept && !w_win;
  assign req1_ready  = w_accept && w_win;
  assign alu_control = r_alu_ctrl;
  assign alu_src1    = r_alu_src1;
  assign alu_src2    = r_alu_src2;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_result  = r_rsp_result;
  assign rsp_rem     = r_rsp_rem;
  assign rsp_err     = r_rsp_err;
  assign busy        = (r_state != S_IDLE);
  assign dbg_state   = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_alu_ctrl   <= '0;
      r_alu_src1   <= '0;
      r_alu_src2   <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_rem    <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_last_grant <= w_win;
            r_rsp_id     <= w_win;
            if (w_legal) begin
              r_alu_ctrl <= w_ctrl;
              r_alu_src1 <= w_src1;
              r_alu_src2 <= w_src2;
              r_cnt      <= w_ctrl[3] ? CW'(DIV_CYCLES) : CW'(1);
              r_state    <= S_EXEC;
            end else begin
              // An illegal word never reaches the ALU; it is answered with an error at once.
              r_rsp_err    <= 1'b1;
              r_rsp_result <= '0;
              r_rsp_rem    <= '0;
              r_rsp_valid  <= 1'b1;
              r_state      <= S_RESP;
            end
          end
        end
        S_EXEC: begin
          if (r_cnt == CW'(1)) begin
            r_rsp_result <= alu_result;
            r_rsp_rem    <= div_odd;
            r_rsp_err    <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_alu_ctrl   <= '0;
            r_alu_src1   <= '0;
            r_alu_src2   <= '0;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single ALU datapath between two requesters (for example the execute stage and a microcode or debug port), with round-robin arbitration and valid/ready handshakes. Each granted operation is registered onto the ALU inputs and held stable for its execution window. Divide operations get a multi-cycle window, because the divider is a long combinational path. The result and remainder are captured into a response register, which is held until the consumer accepts it.

## Interface
- DIV_CYCLES, default 4: cycles the ALU inputs are held for a divide (control bit 3) before capture; legal values are 1 or more.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_ctrl  in  15  one-hot ALU control (bit0 add … bit13 lui)
- req0_src1 / req0_src2  in  32  operands
- req1_valid, req1_ready, req1_ctrl, req1_src1, req1_src2: same as requester 0, for requester 1
- alu_control  out  15  to ALU
- alu_src1 / alu_src2  out  32  to ALU
- alu_result  in  32  from ALU
- div_odd  in  32  remainder from ALU
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester the response belongs to
- rsp_result  out  32  captured alu_result
- rsp_rem  out  32  captured div_odd
- rsp_err  out  1  illegal control word
- busy  out  1  state ≠ IDLE

## Operation
- FSM states:
  - IDLE: choose a winner and accept it.
  - EXEC: hold operands on the ALU.
  - RESP: hold the response until it is taken.
- IDLE
  - Winner: if exactly one reqN_valid is high, that requester wins. If both are high, the requester other than last_grant wins.
  - reqN_ready is combinational and is high only in IDLE, only for the winner.
  - On the handshake: latch ctrl, src1, src2 and id, and set last_grant to the winner's id.
- Legality check at accept: the control word is legal only if bit 14 is 0 and bits 13:0 are exactly one-hot.
  - Illegal word: go directly to RESP with rsp_err = 1, rsp_result = 0, rsp_rem = 0. alu_control is never driven non-zero for an illegal word.
  - Legal word: go to EXEC.
- EXEC
  - alu_control, alu_src1 and alu_src2 are driven from registers and held constant for the whole window.
  - Counter load at entry: DIV_CYCLES if ctrl[3] is set, otherwise 1. The counter decrements every cycle.
  - In the cycle the counter equals 1: capture alu_result into rsp_result and div_odd into rsp_rem, set rsp_err = 0, go to RESP.
  - Counter width is $clog2(DIV_CYCLES+1).
- RESP
  - rsp_valid = 1, and all rsp_* outputs are held stable.
  - On rsp_valid & rsp_ready, go to IDLE. New requests are not accepted in the same cycle.
- In IDLE and RESP, alu_control = 0, so the ALU outputs 0 and div_odd = 0.
- rsp_rem is 0 for non-divide operations, because the ALU gates div_odd.
- Requesters must hold valid and payload stable until ready. Dropping valid before ready is permitted; nothing is latched in that case.
- Reset values:
  - state IDLE, last_grant = 1 (so requester 0 wins the first tie).
  - alu_control = 0, alu_src1 = 0, alu_src2 = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_rem = 0, rsp_err = 0.
  - busy = 0, req0_ready = 0, req1_ready = 0.
- Reset mid-operation: the in-flight operation is discarded and no response is produced. All outputs take their reset values on the cycle after rst is sampled high.

## Timing
- Accept at clock edge T, non-divide: EXEC occupies cycle T+1; rsp_valid is high from cycle T+2.
- Accept at T, divide: EXEC occupies T+1 … T+DIV_CYCLES; rsp_valid is high from T+DIV_CYCLES+1.
- Accept at T, illegal control word: rsp_valid is high from T+1.
- With rsp_ready held high, minimum spacing between accepts is 3 cycles for non-divide and DIV_CYCLES+2 for divide.
- Backpressure: if rsp_ready stays low, the block remains in RESP indefinitely and no reqN_ready is asserted.
- ALU inputs change only on the edge that enters or leaves EXEC. The divider therefore always sees stable inputs for DIV_CYCLES full cycles.

## Test plan
- Add on requester 0: src1 = 5, src2 = 7, ctrl 0x0001 → req0_ready high 1 cycle; rsp_valid 2 cycles after accept with rsp_result = 12, rsp_rem = 0, rsp_id = 0, rsp_err = 0.
- Divide on requester 1 with DIV_CYCLES = 4: src1 = 100, src2 = 7, ctrl 0x0008 → alu_* stable 4 cycles; rsp_valid at accept+5 with rsp_result = 14, rsp_rem = 2, rsp_id = 1.
- Both requesters continuously valid after reset with rsp_ready = 1 → grant sequence 0, 1, 0, 1; each rsp_id matches its grant.
- Backpressure: rsp_ready = 0 for 10 cycles in RESP → rsp_* unchanged, busy = 1, no ready asserted; the response completes on the cycle rsp_ready rises.
- Illegal ctrl 0x0003, then ctrl 0x4001 → alu_control remains 0; rsp_err = 1 and rsp_result = 0 one cycle after each accept.
- rst pulsed during the third EXEC cycle of a divide → all outputs at reset values the next cycle; no rsp_valid; the next tie is granted to requester 0.
